conv_line_buffer: RTL and testbench



---
 rtl/conv_line_buffer_pkg.sv | 26 ++
 rtl/conv_line_buffer_if.sv | 25 ++
 rtl/conv_line_buffer_line_mem.sv | 26 ++
 rtl/conv_line_buffer.sv | 168 ++++++++++++++++
 tb/tb_conv_line_buffer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/conv_line_buffer_pkg.sv
// Shared types and width helpers for the convolution line buffer.
package conv_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        TAIL   = 2'd3
    } state_t;

    localparam int PADDING = 1;

    // Column counter spans the padded row: 0 .. W+2*PADDING-1.
    function automatic int col_w(input int w);
        return $clog2(w + 2 * PADDING);
    endfunction

    function automatic int row_w(input int h);
        return (h > 1) ? $clog2(h) : 1;
    endfunction

    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer_if.sv
// Pixel stream in, zero-padded vertical columns out.
// in_data transfers on a rising clk edge where in_valid && in_ready; in_ready never depends on in_valid.
interface conv_line_buffer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_out0;
    logic [DATA_WIDTH-1:0] data_out1;
    logic [DATA_WIDTH-1:0] data_out2;
    logic                  col_valid;
    logic                  win_valid;
    logic                  busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, data_out0, data_out1, data_out2, col_valid, win_valid, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, data_out0, data_out1, data_out2, col_valid, win_valid, busy
    );
endinterface

// File: rtl/conv_line_buffer_line_mem.sv
// Two row buffers sharing one index: combinational read, synchronous write.
module line_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 28,
    parameter int IDX_W      = 5
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  we_a,
    input  logic [DATA_WIDTH-1:0] wd_a,
    input  logic                  we_b,
    input  logic [DATA_WIDTH-1:0] wd_b,
    output logic [DATA_WIDTH-1:0] rd_a,
    output logic [DATA_WIDTH-1:0] rd_b
);
    logic [DATA_WIDTH-1:0] mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) mem_a[idx] <= wd_a;
        if (we_b) mem_b[idx] <= wd_b;
    end

    assign rd_a = mem_a[idx];
    assign rd_b = mem_b[idx];
endmodule

// File: rtl/conv_line_buffer.sv
// Buffers two image rows and emits one zero-padded 3-pixel column per beat
// for a 3x3 convolution, with column and window strobes.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                clk,
    input  logic                rst,
    conv_line_buffer_if.slave   bus,
    output state_t              state_dbg
);
    localparam int CW = col_w(IMG_WIDTH);
    localparam int RW = row_w(IMG_HEIGHT);
    localparam int IW = idx_w(IMG_WIDTH);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH + 2 * PADDING - 1);
    localparam logic [CW-1:0] COL_FILL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_WIN_FIRST = CW'(2 * PADDING + 1);
    localparam logic [RW-1:0] ROW_PRE_FLUSH = RW'(IMG_HEIGHT - 2);

    state_t          state, state_n;
    logic [CW-1:0]   col, col_n;
    logic [RW-1:0]   row, row_n;
    logic            first_row, first_row_n;
    logic            pad, ready, accept;
    logic            beat, beat_win, busy_n;
    logic [DATA_WIDTH-1:0] beat_d0, beat_d1, beat_d2;

    logic [IW-1:0]         mem_idx;
    logic                  we_a, we_b;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    assign pad     = (col == '0) || (col == COL_LAST);
    assign ready   = (state == FILL) || ((state == STREAM) && !pad);
    assign accept  = bus.in_valid && ready;
    // FILL writes at col; STREAM/FLUSH skip the leading pad column.
    assign mem_idx = (state == FILL) ? col[IW-1:0] : IW'(col - CW'(PADDING));

    line_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .IDX_W      (IW)
    ) u_line_mem (
        .clk  (clk),
        .idx  (mem_idx),
        .we_a (we_a),
        .wd_a (rd_b),
        .we_b (we_b),
        .wd_b (bus.in_data),
        .rd_a (rd_a),
        .rd_b (rd_b)
    );

    always_comb begin
        state_n     = state;
        col_n       = col;
        row_n       = row;
        first_row_n = first_row;
        beat        = 1'b0;
        beat_win    = 1'b0;
        beat_d0     = '0;
        beat_d1     = '0;
        beat_d2     = '0;
        we_a        = 1'b0;
        we_b        = 1'b0;
        busy_n      = 1'b1;

        case (state)
            FILL: begin
                // Stays busy once any pixel of this frame has been taken.
                busy_n = (col != '0) || accept;
                if (accept) begin
                    we_b = 1'b1;
                    if (col == COL_FILL_LAST) begin
                        col_n       = '0;
                        row_n       = '0;
                        first_row_n = 1'b1;
                        state_n     = STREAM;
                    end else begin
                        col_n = col + CW'(1);
                    end
                end
            end
            STREAM: begin
                if (pad) begin
                    beat = 1'b1;
                end else if (accept) begin
                    beat    = 1'b1;
                    beat_d0 = first_row ? '0 : rd_a;
                    beat_d1 = rd_b;
                    beat_d2 = bus.in_data;
                    we_a    = 1'b1;
                    we_b    = 1'b1;
                end
                if (beat) begin
                    if (col == COL_LAST) begin
                        col_n       = '0;
                        first_row_n = 1'b0;
                        row_n       = row + RW'(1);
                        if (row == ROW_PRE_FLUSH) state_n = FLUSH;
                    end else begin
                        col_n = col + CW'(1);
                    end
                end
            end
            FLUSH: begin
                beat = 1'b1;
                if (!pad) begin
                    beat_d0 = rd_a;
                    beat_d1 = rd_b;
                end
                if (col == COL_LAST) begin
                    col_n   = '0;
                    state_n = TAIL;
                end else begin
                    col_n = col + CW'(1);
                end
            end
            TAIL: begin
                beat     = 1'b1;
                beat_win = 1'b1;
                col_n    = '0;
                row_n    = '0;
                state_n  = FILL;
            end
            default: state_n = FILL;
        endcase

        // Window completes on the third real column onward, and on the
        // leading pad of every row but the first (closes the previous row).
        if ((state == STREAM) || (state == FLUSH)) begin
            beat_win = beat && ((col >= COL_WIN_FIRST) ||
                                ((col == '0) && !((state == STREAM) && first_row)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL;
            col           <= '0;
            row           <= '0;
            first_row     <= 1'b0;
            bus.data_out0 <= '0;
            bus.data_out1 <= '0;
            bus.data_out2 <= '0;
            bus.col_valid <= 1'b0;
            bus.win_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_n;
            col           <= col_n;
            row           <= row_n;
            first_row     <= first_row_n;
            bus.data_out0 <= beat_d0;
            bus.data_out1 <= beat_d1;
            bus.data_out2 <= beat_d2;
            bus.col_valid <= beat;
            bus.win_valid <= beat_win;
            bus.busy      <= busy_n;
        end
    end

    assign bus.in_ready = ready && !rst;
    assign state_dbg    = state;
endmodule

// File: tb/tb_conv_line_buffer.sv
// Directed bench for conv_line_buffer at W=4, H=3 with pixel(r,c) = 10r + c + 1.
module tb_conv_line_buffer;
    import conv_pkg::*;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 3;

    logic   clk = 1'b0;
    logic   rst;
    state_t state_dbg;

    conv_line_buffer_if #(.DATA_WIDTH(DW)) bus ();

    conv_line_buffer #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [63:0] exp_q[$];
    int          beat_cnt;
    int          win_cnt;
    int          acc_cnt;
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'(10 * r + c + 1);
    endfunction

    function automatic logic [63:0] pack(input bit win, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b, input logic [DW-1:0] c);
        return {15'd0, win, a, b, c};
    endfunction

    // Expected column stream: padded 3x3 neighbourhood, one column per beat, then a tail.
    task automatic load_expected();
        exp_q.delete();
        for (int orow = 0; orow < H; orow++) begin
            for (int c = 0; c < W + 2; c++) begin
                bit win;
                logic [DW-1:0] top, mid, bot;
                win = (c >= 3) || (c == 0 && orow != 0);
                top = '0; mid = '0; bot = '0;
                if (c >= 1 && c <= W) begin
                    top = (orow == 0)     ? '0 : pix(orow - 1, c - 1);
                    mid = pix(orow, c - 1);
                    bot = (orow == H - 1) ? '0 : pix(orow + 1, c - 1);
                end
                exp_q.push_back(pack(win, top, mid, bot));
            end
        end
        exp_q.push_back(pack(1'b1, '0, '0, '0));
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.col_valid) begin
            beat_cnt++;
            if (bus.win_valid) win_cnt++;
            if (exp_q.size() == 0)
                check("extra_beat", 64'd1, 64'd0);
            else
                check($sformatf("beat%0d", beat_cnt),
                      pack(bus.win_valid, bus.data_out0, bus.data_out1, bus.data_out2),
                      exp_q.pop_front());
        end
    end

    task automatic run_frame(input bit gaps, input string name);
        int idx;
        int cyc;
        load_expected();
        beat_cnt = 0;
        win_cnt  = 0;
        acc_cnt  = 0;
        idx      = 0;
        cyc      = 0;
        while (idx < W * H && cyc < 1000) begin
            @(negedge clk);
            bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_data  = pix(idx / W, idx % W);
            if (bus.in_valid && bus.in_ready) begin
                idx++;
                acc_cnt++;
            end
            cyc++;
        end
        check({name, "_send_done"}, 64'(idx), 64'(W * H));
        // Keep offering junk through pad/flush/tail: none of it may be taken.
        @(negedge clk);
        cyc = 0;
        while (state_dbg != FILL && cyc < 200) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h7fff;
            if (bus.in_ready) acc_cnt++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check({name, "_reached_fill"}, 64'(state_dbg == FILL), 64'd1);
        check({name, "_busy_tail"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
        check({name, "_busy_fall"}, 64'(bus.busy), 64'd0);
        check({name, "_beats"}, 64'(beat_cnt), 64'(H * (W + 2) + 1));
        check({name, "_windows"}, 64'(win_cnt), 64'(H * W));
        check({name, "_accepted"}, 64'(acc_cnt), 64'(W * H));
        check({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int idx;
        int cyc;

        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out0", 64'(bus.data_out0), 64'd0);
        check("rst_out1", 64'(bus.data_out1), 64'd0);
        check("rst_out2", 64'(bus.data_out2), 64'd0);
        check("rst_col_valid", 64'(bus.col_valid), 64'd0);
        check("rst_win_valid", 64'(bus.win_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_state", 64'(state_dbg), 64'(FILL));

        mon_en = 1'b1;
        run_frame(1'b0, "clean");
        run_frame(1'b1, "gaps");

        // Abandon a frame partway into the first output row.
        mon_en = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 7 && cyc < 200) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(16'h0100 + idx);
            if (bus.in_ready) idx++;
            cyc++;
        end
        check("partial_accepts", 64'(idx), 64'd7);
        @(negedge clk);
        check("partial_in_stream", 64'(state_dbg), 64'(STREAM));
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_state", 64'(state_dbg), 64'(FILL));
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_col_valid", 64'(bus.col_valid), 64'd0);
        mon_en = 1'b1;
        run_frame(1'b0, "after_rst");

        repeat (3) @(negedge clk);
        check("idle_no_beats", 64'(beat_cnt), 64'(H * (W + 2) + 1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
